mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port MIPS data memory. Shares the memory between the load/store unit (D port, read/write) and the instruction-fetch unit (I port, read-only), one access per cycle, and routes registered read data back to the correct requester. Sits between the pipeline and the memory. It drives the memory's `mem_to_reg` select so that no write happens unless a granted write is in flight.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_policy.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory port arbiter: port IDs and default widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_CNT_W   = 4;

    typedef logic port_id_t;

    localparam port_id_t PORT_D = 1'b0;
    localparam port_id_t PORT_I = 1'b1;

endpackage

// File: rtl/mem_arb_policy.sv
// Conflict policy for the D/I memory ports; picks at most one winner per cycle.
// MEM_ARB_RR_EN selects round-robin, otherwise D-priority with an I starvation guard.
module mem_arb_policy
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_req,
    input  logic i_req,
    output logic d_win,
    output logic i_win
);

`ifdef MEM_ARB_RR_EN
    port_id_t rr_last_q, rr_last_d;

    // On conflict the port that was not granted most recently goes next.
    always_comb begin
        i_win     = i_req & (~d_req | (rr_last_q == PORT_D));
        d_win     = d_req & ~i_win;
        rr_last_d = rr_last_q;
        if (i_win)      rr_last_d = PORT_I;
        else if (d_win) rr_last_d = PORT_D;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_last_q <= PORT_I;
        else          rr_last_q <= rr_last_d;
    end
`else
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    conflict;

    // D wins conflicts until I has lost STARVE_MAX of them in a row.
    always_comb begin
        conflict = d_req & i_req;
        i_win    = i_req & (~d_req | (starve_q == STARVE_CNT_W'(STARVE_MAX)));
        d_win    = d_req & ~i_win;
        starve_d = starve_q;
        if (i_win)         starve_d = '0;
        else if (conflict) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between the load/store (D) and fetch (I) ports.
// Policy build option: MEM_ARB_RR_EN (round-robin); default is D-priority with starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic     d_win, i_win;
    logic     rd_pend_q, rd_pend_d;
    port_id_t rd_owner_q, rd_owner_d;

    mem_arb_policy #(
        .STARVE_MAX (STARVE_MAX)
    ) u_policy (
        .clk     (clk),
        .reset_n (reset_n),
        .d_req   (d_req),
        .i_req   (i_req),
        .d_win   (d_win),
        .i_win   (i_win)
    );

    // Grants are combinational, so they must also be masked while reset is held.
    assign d_gnt = d_win & reset_n;
    assign i_gnt = i_win & reset_n;

    // Idle cycles present a read of address 0 so the memory never writes by accident.
    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_to_reg     = 1'b1;
        if (i_gnt) begin
            mem_address = i_addr;
        end else if (d_gnt) begin
            mem_address    = d_addr;
            mem_write_data = d_wdata;
            mem_to_reg     = ~d_we;
        end
    end

    always_comb begin
        rd_pend_d  = i_gnt | (d_gnt & ~d_we);
        rd_owner_d = rd_owner_q;
        if (i_gnt)              rd_owner_d = PORT_I;
        else if (d_gnt & ~d_we) rd_owner_d = PORT_D;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= PORT_D;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign d_rvalid = rd_pend_q & (rd_owner_q == PORT_D);
    assign i_rvalid = rd_pend_q & (rd_owner_q == PORT_I);
    assign d_rdata  = d_rvalid ? mem_read_data : '0;
    assign i_rdata  = i_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int MW   = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_to_reg;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] mem     [MW];
    logic [DW-1:0] exp_mem [MW];
    logic          pl_en = 1'b0;
    logic [3:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_to_reg(mem_to_reg), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data; preload is a bench-only side door.
    always @(posedge clk) begin
        if (pl_en)            mem[pl_addr] <= pl_data;
        else if (!mem_to_reg) mem[mem_address[3:0]] <= mem_write_data;
        mem_read_data <= mem[mem_address[3:0]];
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; i_req = 0; i_addr = '0;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] v);
        pl_en = 1'b1; pl_addr = 4'(a); pl_data = v; exp_mem[a] = v;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 1'b0;
        tick; tick;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_inputs();
        for (int a = 0; a < MW; a++) preload(a, 32'h5000_0000 + DW'(a));
        d_req = 1; d_we = 1; d_addr = 5; d_wdata = 32'hFFFF_FFFF; i_req = 1; i_addr = 6;
        #2;
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
        checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL rst_i_gnt: got %b want 0", i_gnt); end
        checks++; if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL rst_mem_to_reg: got %b want 1", mem_to_reg); end
        checks++; if (mem_address !== '0) begin errors++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
        checks++; if (mem_write_data !== '0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_write_data); end
        checks++; if ({d_rvalid, i_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {d_rvalid, i_rvalid}); end
        checks++; if ({d_rdata, i_rdata} !== '0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0", d_rdata, i_rdata); end
        tick;
        checks++; if (mem[5] !== exp_mem[5]) begin errors++; $display("FAIL rst_no_write: got %h want %h", mem[5], exp_mem[5]); end
        idle_inputs();
        reset_n = 1'b1;
        tick;
        // Read granted, then reset lands before the edge that would return it.
        i_req = 1; i_addr = 2;
        #2;
        checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", i_gnt); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({d_gnt, i_gnt} !== 2'b00) begin errors++; $display("FAIL rmid_gnts: got %b want 00", {d_gnt, i_gnt}); end
        checks++; if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL rmid_mem_to_reg: got %b want 1", mem_to_reg); end
        idle_inputs();
        tick;
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid: got %b want 0", i_rvalid); end
        reset_n = 1'b1;
        tick;
        checks++; if ({d_rvalid, i_rvalid} !== 2'b00) begin errors++; $display("FAIL rmid_rvalid2: got %b want 00", {d_rvalid, i_rvalid}); end
    endtask

    task automatic test_write_read;
        do_reset();
        d_req = 1; d_we = 1; d_addr = 3; d_wdata = 32'hDEADBEEF;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", d_gnt); end
        checks++; if (mem_to_reg !== 1'b0) begin errors++; $display("FAIL wr_mem_to_reg: got %b want 0", mem_to_reg); end
        exp_mem[3] = 32'hDEADBEEF;
        tick;
        d_we = 0; d_wdata = '0;
        #2;
        checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", d_gnt); end
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_resp: got %b want 0", d_rvalid); end
        tick;
        idle_inputs();
        #2;
        checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", d_rvalid); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d_rdata); end
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL rd_i_rvalid: got %b want 0", i_rvalid); end
        tick;
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int a = 0; a < 3; a++) preload(a, DW'(10 + a));
        for (int k = 0; k < 5; k++) begin
            i_req = (k < 3); i_addr = AW'(k);
            #2;
            checks++; if (i_gnt !== (k < 3)) begin errors++; $display("FAIL b2b_gnt%0d: got %b want %b", k, i_gnt, (k < 3)); end
            checks++; if (i_rvalid !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL b2b_rvalid%0d: got %b want %b", k, i_rvalid, (k >= 1 && k <= 3)); end
            if (k >= 1 && k <= 3) begin
                checks++; if (i_rdata !== DW'(9 + k)) begin errors++; $display("FAIL b2b_data%0d: got %0d want %0d", k, i_rdata, 9 + k); end
            end
            checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_d_rvalid%0d: got %b want 0", k, d_rvalid); end
            tick;
        end
        idle_inputs();
    endtask

    task automatic test_conflict;
        bit            prev_i, prev_any;
        logic [DW-1:0] prev_data;
        bit            exp_i;
        do_reset();
        prev_any = 0; prev_i = 0; prev_data = '0;
        for (int k = 0; k < 11; k++) begin
            d_req = (k < 10); d_we = 0; d_addr = AW'(k % MW);
            i_req = (k < 10); i_addr = AW'((k + 5) % MW);
            exp_i = RR ? (k % 2 == 1) : (k % (SMAX + 1) == SMAX);
            #2;
            if (k < 10) begin
                checks++; if (i_gnt !== exp_i) begin errors++; $display("FAIL conf_i_gnt%0d: got %b want %b", k, i_gnt, exp_i); end
                checks++; if (d_gnt !== !exp_i) begin errors++; $display("FAIL conf_d_gnt%0d: got %b want %b", k, d_gnt, !exp_i); end
            end
            if (prev_any) begin
                checks++; if ({i_rvalid, d_rvalid} !== {prev_i, !prev_i}) begin errors++; $display("FAIL conf_route%0d: got %b want %b", k, {i_rvalid, d_rvalid}, {prev_i, !prev_i}); end
                checks++; if ((i_rdata | d_rdata) !== prev_data) begin errors++; $display("FAIL conf_data%0d: got %h want %h", k, i_rdata | d_rdata, prev_data); end
            end
            prev_any  = (k < 10);
            prev_i    = exp_i;
            prev_data = exp_i ? exp_mem[(k + 5) % MW] : exp_mem[k % MW];
            tick;
        end
        idle_inputs();
    endtask

    task automatic test_mixed;
        do_reset();
        preload(7, 32'h1111_1111);
        d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'hCAFEF00D; i_req = 1; i_addr = 7;
        #2;
        checks++; if ({d_gnt, i_gnt} !== 2'b10) begin errors++; $display("FAIL mix_first: got %b want 10", {d_gnt, i_gnt}); end
        exp_mem[7] = 32'hCAFEF00D;
        tick;
        d_req = 0; d_we = 0;
        #2;
        checks++; if ({d_gnt, i_gnt} !== 2'b01) begin errors++; $display("FAIL mix_second: got %b want 01", {d_gnt, i_gnt}); end
        checks++; if ({d_rvalid, i_rvalid} !== 2'b00) begin errors++; $display("FAIL mix_no_resp: got %b want 00", {d_rvalid, i_rvalid}); end
        tick;
        idle_inputs();
        #2;
        checks++; if ({d_rvalid, i_rvalid} !== 2'b01) begin errors++; $display("FAIL mix_resp: got %b want 01", {d_rvalid, i_rvalid}); end
        checks++; if (i_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL mix_data: got %h want cafef00d", i_rdata); end
        checks++; if (d_rdata !== '0) begin errors++; $display("FAIL mix_d_rdata: got %h want 0", d_rdata); end
        tick;
    endtask

    task automatic test_random;
        bit            last_i;   // most recent grant went to I
        int            losses;   // consecutive conflicts lost by I
        bit            pend, own_i, e_d, e_i;
        logic [DW-1:0] rd;
        do_reset();
        last_i = 1; losses = 0; pend = 0; own_i = 0; rd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, MW - 1)); d_wdata = $urandom;
            end
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_addr = AW'($urandom_range(0, MW - 1));
            end
            #2;
            if (d_req && i_req) e_i = RR ? last_i == 0 : losses == SMAX;
            else                e_i = i_req;
            e_d = d_req && !e_i;
            checks++; if ({d_gnt, i_gnt} !== {e_d, e_i}) begin errors++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, {d_gnt, i_gnt}, {e_d, e_i}); end
            checks++; if (mem_to_reg !== !(e_d && d_we)) begin errors++; $display("FAIL rnd_mem_to_reg c%0d: got %b want %b", c, mem_to_reg, !(e_d && d_we)); end
            checks++; if ({d_rvalid, i_rvalid} !== {pend && !own_i, pend && own_i}) begin errors++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, {d_rvalid, i_rvalid}, {pend && !own_i, pend && own_i}); end
            checks++; if (d_rdata !== ((pend && !own_i) ? rd : '0)) begin errors++; $display("FAIL rnd_d_rdata c%0d: got %h want %h", c, d_rdata, (pend && !own_i) ? rd : '0); end
            checks++; if (i_rdata !== ((pend && own_i) ? rd : '0)) begin errors++; $display("FAIL rnd_i_rdata c%0d: got %h want %h", c, i_rdata, (pend && own_i) ? rd : '0); end
            pend = 0;
            if (e_i) begin
                pend = 1; own_i = 1; rd = exp_mem[i_addr[3:0]]; last_i = 1; losses = 0;
            end else if (e_d) begin
                last_i = 0;
                if (i_req) losses++;
                if (d_we) exp_mem[d_addr[3:0]] = d_wdata;
                else begin pend = 1; own_i = 0; rd = exp_mem[d_addr[3:0]]; end
            end
            tick;
            if (e_d) d_req = 0;
            if (e_i) i_req = 0;
        end
        idle_inputs();
        tick;
    endtask

    task automatic test_idle;
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            #2;
            checks++; if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL idle_mem_to_reg%0d: got %b want 1", k, mem_to_reg); end
            tick;
        end
        for (int a = 0; a < MW; a++) begin
            checks++; if (mem[a] !== exp_mem[a]) begin errors++; $display("FAIL idle_mem%0d: got %h want %h", a, mem[a], exp_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_conflict();
        test_mixed();
        test_random();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
